// File: rtl/mem_ctrl.sv
// mem_ctrl: burst read/write master for a tri-state single-port memory.
// Define MEM_CTRL_TURNAROUND_EN to add one bus turnaround cycle after read bursts.
module mem_ctrl #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8,
    parameter int LWIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [LWIDTH-1:0] req_len,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DWIDTH-1:0] wdata,
    output logic              rdata_valid,
    output logic [DWIDTH-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [AWIDTH-1:0] mem_addr,
    inout  wire  [DWIDTH-1:0] mem_data
);
`ifdef MEM_CTRL_TURNAROUND_EN
    typedef enum logic [2:0] {IDLE, WR, RD_ADDR, RD_CAP, DONE, TURN} state_t;
    logic last_rd;
`else
    typedef enum logic [2:0] {IDLE, WR, RD_ADDR, RD_CAP, DONE} state_t;
`endif
    state_t state;
    logic [AWIDTH-1:0] cur;
    logic [LWIDTH-1:0] cnt;
    logic [DWIDTH-1:0] wbuf;
    assign req_ready   = state == IDLE;
    assign wdata_ready = state == WR;
    // mem_wr is registered, so the bus is driven exactly during the write strobe cycle
    assign mem_data    = mem_wr ? wbuf : {DWIDTH{1'bz}};
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cur         <= '0;
            cnt         <= '0;
            wbuf        <= '0;
            mem_wr      <= 1'b0;
            mem_rd      <= 1'b0;
            mem_addr    <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
`ifdef MEM_CTRL_TURNAROUND_EN
            last_rd     <= 1'b0;
`endif
        end else begin
            rdata_valid <= 1'b0;
            done        <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    cur      <= req_addr;
                    cnt      <= req_len;
                    mem_addr <= req_addr;
                    busy     <= 1'b1;
                    mem_rd   <= !req_write;
                    state    <= req_write ? WR : RD_ADDR;
`ifdef MEM_CTRL_TURNAROUND_EN
                    last_rd  <= !req_write;
`endif
                end
                WR: if (wdata_valid) begin
                    mem_wr   <= 1'b1;
                    mem_addr <= cur;
                    wbuf     <= wdata;
                    cur      <= cur + 1'b1;
                    cnt      <= cnt - 1'b1;
                    if (cnt == '0)
                        state <= DONE;
                end else begin
                    mem_wr <= 1'b0;
                end
                RD_ADDR: state <= RD_CAP;
                RD_CAP: begin
                    rdata       <= mem_data;
                    rdata_valid <= 1'b1;
                    if (cnt == '0) begin
                        mem_rd <= 1'b0;
                        state  <= DONE;
                    end else begin
                        cnt      <= cnt - 1'b1;
                        cur      <= cur + 1'b1;
                        mem_addr <= cur + 1'b1;
                        state    <= RD_ADDR;
                    end
                end
                DONE: begin
                    mem_wr <= 1'b0;
                    mem_rd <= 1'b0;
                    done   <= 1'b1;
`ifdef MEM_CTRL_TURNAROUND_EN
                    busy   <= last_rd;
                    state  <= last_rd ? TURN : IDLE;
                end
                TURN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
`else
                    busy   <= 1'b0;
                    state  <= IDLE;
`endif
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed vector bench for mem_ctrl with a behavioural tri-state memory.
module tb_mem_ctrl;
    localparam int AW = 5, DW = 8, LW = 4;
`ifdef MEM_CTRL_TURNAROUND_EN
    localparam bit TA = 1'b1;
`else
    localparam bit TA = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1;
    logic req_valid = 1'b0, req_write = 1'b0, wdata_valid = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [LW-1:0] req_len = '0;
    logic [DW-1:0] wdata = '0;
    logic req_ready, wdata_ready, rdata_valid, busy, done, mem_wr, mem_rd;
    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_addr;
    wire  [DW-1:0] mem_data;
    logic [DW-1:0] mem [2**AW];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    mem_ctrl #(.AWIDTH(AW), .DWIDTH(DW), .LWIDTH(LW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata(rdata), .busy(busy), .done(done),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data)
    );

    assign mem_data = mem_rd ? mem[mem_addr] : {DW{1'bz}};
    always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_data;

    always @(negedge clk) begin
        checks++;
        if (mem_wr && mem_rd) begin
            errors++;
            $display("FAIL bus_contention: mem_wr=%0b mem_rd=%0b expected never both 1", mem_wr, mem_rd);
        end
    end

    typedef struct {
        logic               wr;
        logic [AW-1:0]      addr;
        logic [LW-1:0]      len;
        logic               gap;
        logic [3:0][AW-1:0] ea;
        logic [3:0][DW-1:0] d;
    } vec_t;
    vec_t v [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 8 && !req_ready; k++) @(negedge clk);
        if (!req_ready) chk("req_ready_timeout", req_ready, 1);
    endtask

    task automatic run(input vec_t t);
        req_valid = 1'b1;
        req_write = t.wr;
        req_addr  = t.addr;
        req_len   = t.len;
        chk("req_ready", req_ready, 1);
        cyc();
        req_valid = 1'b0;
        chk("busy", busy, 1);
        chk("done_width", done, 0);
        if (t.wr) begin
            for (int b = 0; b <= int'(t.len); b++) begin
                if (t.gap && b == 2) begin
                    wdata_valid = 1'b0;
                    cyc();
                    chk("wr_gap", mem_wr, 0);
                end
                wdata_valid = 1'b1;
                wdata = t.d[b];
                chk("wdata_ready", wdata_ready, 1);
                cyc();
                chk("wr_strobe", mem_wr, 1);
                chk("wr_addr", mem_addr, t.ea[b]);
                chk("wr_data", mem_data, t.d[b]);
                chk("wr_done_early", done, 0);
            end
            wdata_valid = 1'b0;
            cyc();
            chk("wr_done", done, 1);
            chk("wr_strobe_off", mem_wr, 0);
        end else begin
            chk("rd_first_strobe", mem_rd, 1);
            chk("rd_first_addr", mem_addr, t.ea[0]);
            for (int b = 0; b <= int'(t.len); b++) begin
                cyc();
                chk("rd_cap_strobe", mem_rd, 1);
                chk("rd_cap_addr", mem_addr, t.ea[b]);
                chk("rd_valid_gap", rdata_valid, 0);
                cyc();
                chk("rd_valid", rdata_valid, 1);
                chk("rd_data", rdata, t.d[b]);
                chk("rd_strobe_next", mem_rd, b < int'(t.len));
                if (b < int'(t.len)) chk("rd_next_addr", mem_addr, t.ea[b+1]);
            end
            cyc();
            chk("rd_done", done, 1);
            chk("rd_strobe_off", mem_rd, 0);
            chk("rd_valid_off", rdata_valid, 0);
        end
        chk("ready_after_done", req_ready, t.wr ? 1 : !TA);
    endtask

    initial begin
        v[0] = '{1'b1, 5'd3,  4'd0, 1'b0, {5'd0, 5'd0, 5'd0,  5'd3},  32'h000000A5};
        v[1] = '{1'b0, 5'd3,  4'd0, 1'b0, {5'd0, 5'd0, 5'd0,  5'd3},  32'h000000A5};
        v[2] = '{1'b1, 5'd30, 4'd3, 1'b1, {5'd1, 5'd0, 5'd31, 5'd30}, 32'h04030201};
        v[3] = '{1'b0, 5'd30, 4'd3, 1'b0, {5'd1, 5'd0, 5'd31, 5'd30}, 32'h04030201};
        v[4] = '{1'b1, 5'd16, 4'd1, 1'b0, {5'd0, 5'd0, 5'd17, 5'd16}, 32'h0000C35C};
        v[5] = '{1'b0, 5'd16, 4'd1, 1'b0, {5'd0, 5'd0, 5'd17, 5'd16}, 32'h0000C35C};
        v[6] = '{1'b0, 5'd31, 4'd1, 1'b0, {5'd0, 5'd0, 5'd0,  5'd31}, 32'h00000302};
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rdata_valid", rdata_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_req_ready", req_ready, 1);
        rst = 1'b0;
        wdata_valid = 1'b1;
        wdata = 8'hFF;
        chk("idle_wdata_ready", wdata_ready, 0);
        cyc();
        chk("idle_wdata_ignored", mem_wr, 0);
        chk("idle_busy", busy, 0);
        wdata_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            wait_ready();
            run(v[i]);
        end
        wait_ready();
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 5'd0;
        req_len   = 4'd3;
        cyc();
        req_valid = 1'b0;
        cyc();
        chk("abort_pre_rd", mem_rd, 1);
        rst = 1'b1;
        cyc();
        chk("abort_mem_rd", mem_rd, 0);
        chk("abort_mem_wr", mem_wr, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_rdata_valid", rdata_valid, 0);
        cyc();
        rst = 1'b0;
        cyc();
        chk("abort_no_done", done, 0);
        chk("abort_idle_busy", busy, 0);
        chk("abort_req_ready", req_ready, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
